// File: rtl/vehicle_sensor_conditioner_pkg.sv
// Shared constants and FSM state encoding for the loop-detector conditioner.
package vehicle_sensor_conditioner_pkg;

  // Controller clock rate: one tick is 20 ms.
  localparam int TICKS_PER_SEC = 50;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUALIFY = 3'd1,
    PRESENT = 3'd2,
    HOLD    = 3'd3,
    FAULT   = 3'd4
  } vsc_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vehicle_sensor_conditioner_sync.sv
// Reset-to-0 two-flop synchroniser for a single asynchronous input.
module sync_2ff (
  input  logic clk,
  input  logic rst_bar,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vehicle_sensor_conditioner.sv
// Loop-detector conditioner: synchronise, debounce, hold-stretch, stuck-on
// detection and a saturating vehicle counter feeding the light controller.
module vehicle_sensor_conditioner
  import vehicle_sensor_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 5,
  parameter int HOLD_TICKS     = 100,
  parameter int STUCK_TICKS    = 15000,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_bar,
  input  logic             loop_raw,
  input  logic             count_clr,
  output logic             sensor,
  output logic             arrival,
  output logic             fault,
  output logic [CNT_W-1:0] vehicle_count
);

  // One counter serves debounce, hold and stuck timing, so size it for the
  // longest of them.
  localparam int CW = $clog2(max2(STUCK_TICKS, HOLD_TICKS));
  localparam logic [CW-1:0]    DEB_LAST   = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [CW-1:0]    HOLD_LAST  = CW'(HOLD_TICKS - 1);
  localparam logic [CW-1:0]    STUCK_LAST = CW'(STUCK_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic          raw_s;
  vsc_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          arrival_d;

  sync_2ff u_sync (
    .clk     (clk),
    .rst_bar (rst_bar),
    .d       (loop_raw),
    .q       (raw_s)
  );

  // State, shared counter and registered arrival pulse.
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      arrival <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      arrival <= arrival_d;
    end
  end

  // Next-state and counter rules; arrival only on the debounce-qualified entry.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    arrival_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (raw_s) begin
          state_d = QUALIFY;
          cnt_d   = CW'(1);
        end
      end
      QUALIFY: begin
        if (!raw_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = PRESENT;
          cnt_d     = '0;
          arrival_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESENT: begin
        if (!raw_s) begin
          state_d = HOLD;
          cnt_d   = CW'(1);
        end else if (cnt_q == STUCK_LAST) begin
          state_d = FAULT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        // Loop re-occupied during hold is the same vehicle: no new arrival.
        if (raw_s) begin
          state_d = PRESENT;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FAULT: begin
        // Needs a debounced run of absence to recover; any presence restarts it.
        if (raw_s) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Fail-safe: a stuck loop keeps the country road served.
  assign sensor = (state_q == PRESENT) || (state_q == HOLD) || (state_q == FAULT);
  assign fault  = (state_q == FAULT);

  // Saturating arrivals counter; a coincident clear still keeps the arrival.
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      vehicle_count <= '0;
    end else if (arrival) begin
      if (count_clr)                   vehicle_count <= CNT_W'(1);
      else if (vehicle_count != CNT_MAX) vehicle_count <= vehicle_count + CNT_W'(1);
    end else if (count_clr) begin
      vehicle_count <= '0;
    end
  end

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Randomised and directed bench for vehicle_sensor_conditioner with a
// run-length behavioural model of loop occupancy.
module tb_vehicle_sensor_conditioner;

  localparam int DEB   = 5;
  localparam int HOLD  = 20;
  localparam int STUCK = 300;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_bar = 1'b0;
  logic             loop_raw = 1'b0;
  logic             count_clr = 1'b0;
  logic             sensor, arrival, fault;
  logic [CNT_W-1:0] vehicle_count;

  int checks = 0;
  int failures = 0;

  vehicle_sensor_conditioner #(
    .DEBOUNCE_TICKS (DEB),
    .HOLD_TICKS     (HOLD),
    .STUCK_TICKS    (STUCK),
    .CNT_W          (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_bar       (rst_bar),
    .loop_raw      (loop_raw),
    .count_clr     (count_clr),
    .sensor        (sensor),
    .arrival       (arrival),
    .fault         (fault),
    .vehicle_count (vehicle_count)
  );

  always #10 clk = ~clk;

  // Model: two-sample delay line, then runs of high/low samples decide occupancy.
  bit m_s1, m_s2, m_occ, m_flt, m_arr;
  int m_hi, m_lo, m_base, m_cnt;

  function automatic void reset_model();
    m_s1 = 0; m_s2 = 0; m_occ = 0; m_flt = 0; m_arr = 0;
    m_hi = 0; m_lo = 0; m_base = 0; m_cnt = 0;
  endfunction

  function automatic void model_edge(input bit raw_now, input bit clr);
    bit rs;
    bit arr_prev;
    rs = m_s2;
    arr_prev = m_arr;
    m_s2 = m_s1;
    m_s1 = raw_now;
    if (arr_prev)  m_cnt = clr ? 1 : ((m_cnt < MAXC) ? m_cnt + 1 : m_cnt);
    else if (clr)  m_cnt = 0;
    m_arr = 0;
    if (rs) begin m_hi++; m_lo = 0; end
    else    begin m_lo++; m_hi = 0; end
    if (m_flt) begin
      if (m_lo == DEB) begin m_flt = 0; m_occ = 0; end
    end else if (m_occ) begin
      if (rs) begin
        if (m_hi == 1) m_base = 1;          // vehicle back during hold
        if (m_hi - m_base == STUCK) m_flt = 1;
      end else if (m_lo == HOLD) begin
        m_occ = 0;
      end
    end else if (rs && m_hi == DEB) begin
      m_occ = 1; m_base = DEB; m_arr = 1;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst_bar) model_edge(loop_raw, count_clr);
    else         reset_model();
    #1;
  endtask

  task automatic test_reset();
    rst_bar = 1'b0;
    reset_model();
    for (int i = 0; i < 20; i++) begin
      loop_raw = i[0];
      step();
      checks++;
      if ({sensor, arrival, fault, vehicle_count} !== '0) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d got s=%b a=%b f=%b c=%0d want all 0", i, sensor, arrival, fault, vehicle_count);
      end
    end
    loop_raw = 1'b0;
    @(negedge clk);
    rst_bar = 1'b1;
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (sensor !== 1'b0 || arrival !== 1'b0 || fault !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle got s=%b a=%b f=%b want 0", sensor, arrival, fault);
    end
  endtask

  task automatic test_clean_arrival();
    int n;
    int c0;
    c0 = int'(vehicle_count);
    loop_raw = 1'b1;
    n = 0;
    while (sensor !== 1'b1 && n < 50) begin step(); n++; end
    checks++;
    if (n !== DEB + 2) begin
      failures++;
      $display("FAIL clean_latency got %0d clocks want %0d", n, DEB + 2);
    end
    checks++;
    if (arrival !== 1'b1) begin
      failures++;
      $display("FAIL clean_arrival_aligned got %b want 1", arrival);
    end
    step();
    checks++;
    if (arrival !== 1'b0 || vehicle_count !== CNT_W'(c0 + 1)) begin
      failures++;
      $display("FAIL clean_pulse_count got a=%b c=%0d want a=0 c=%0d", arrival, vehicle_count, c0 + 1);
    end
    for (int i = 0; i < 30; i++) step();
    loop_raw = 1'b0;
    n = 0;
    while (sensor !== 1'b0 && n < 200) begin step(); n++; end
    checks++;
    if (n !== HOLD + 2) begin
      failures++;
      $display("FAIL clean_release got %0d clocks want %0d", n, HOLD + 2);
    end
  endtask

  task automatic test_bounce();
    int c0;
    c0 = int'(vehicle_count);
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 4; i++) begin
        loop_raw = (i < 3);
        step();
        checks++;
        if (sensor !== 1'b0 || arrival !== 1'b0) begin
          failures++;
          $display("FAIL bounce_quiet got s=%b a=%b want 0", sensor, arrival);
        end
      end
    end
    loop_raw = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (vehicle_count !== CNT_W'(c0)) begin
      failures++;
      $display("FAIL bounce_count got %0d want %0d", vehicle_count, c0);
    end
  endtask

  task automatic test_hold_reentry();
    int c0;
    int n;
    c0 = int'(vehicle_count);
    loop_raw = 1'b1;
    for (int i = 0; i < DEB + 2; i++) step();
    for (int i = 0; i < 60; i++) begin
      loop_raw = !(i >= 20 && i < 30);
      step();
      checks++;
      if (sensor !== 1'b1) begin
        failures++;
        $display("FAIL reentry_sensor cyc=%0d got %b want 1", i, sensor);
      end
    end
    loop_raw = 1'b0;
    n = 0;
    while (sensor !== 1'b0 && n < 200) begin step(); n++; end
    checks++;
    if (n !== HOLD + 2 || vehicle_count !== CNT_W'(c0 + 1)) begin
      failures++;
      $display("FAIL reentry_release got n=%0d c=%0d want n=%0d c=%0d", n, vehicle_count, HOLD + 2, c0 + 1);
    end
  endtask

  task automatic test_stuck();
    int n;
    loop_raw = 1'b1;
    n = 0;
    while (fault !== 1'b1 && n < STUCK + 50) begin step(); n++; end
    checks++;
    if (n !== DEB + STUCK + 2 || sensor !== 1'b1) begin
      failures++;
      $display("FAIL stuck_fault got n=%0d s=%b want n=%0d s=1", n, sensor, DEB + STUCK + 2);
    end
    for (int i = 0; i < 20; i++) step();
    loop_raw = 1'b0;
    n = 0;
    while (fault !== 1'b0 && n < 50) begin
      step(); n++;
      if (fault === 1'b1) begin
        checks++;
        if (sensor !== 1'b1) begin
          failures++;
          $display("FAIL stuck_failsafe got s=%b want 1", sensor);
        end
      end
    end
    checks++;
    if (n !== DEB + 2 || sensor !== 1'b0) begin
      failures++;
      $display("FAIL stuck_recover got n=%0d s=%b want n=%0d s=0", n, sensor, DEB + 2);
    end
    for (int i = 0; i < 5; i++) step();
  endtask

  task automatic test_counter();
    int n;
    for (int k = 0; k < MAXC + 2; k++) begin
      loop_raw = 1'b1;
      for (int i = 0; i < DEB + 4; i++) step();
      loop_raw = 1'b0;
      for (int i = 0; i < HOLD + 4; i++) step();
    end
    checks++;
    if (vehicle_count !== CNT_W'(MAXC)) begin
      failures++;
      $display("FAIL count_saturate got %0d want %0d", vehicle_count, MAXC);
    end
    loop_raw = 1'b1;
    n = 0;
    while (arrival !== 1'b1 && n < 50) begin step(); n++; end
    count_clr = 1'b1;
    step();
    count_clr = 1'b0;
    checks++;
    if (vehicle_count !== CNT_W'(1)) begin
      failures++;
      $display("FAIL count_clr_with_arrival got %0d want 1", vehicle_count);
    end
    count_clr = 1'b1;
    step();
    count_clr = 1'b0;
    checks++;
    if (vehicle_count !== '0) begin
      failures++;
      $display("FAIL count_clr_alone got %0d want 0", vehicle_count);
    end
    loop_raw = 1'b0;
    for (int i = 0; i < HOLD + 4; i++) step();
  endtask

  task automatic test_reset_midop();
    loop_raw = 1'b1;
    for (int i = 0; i < DEB + 4; i++) step();
    #3 rst_bar = 1'b0;
    #1;
    checks++;
    if ({sensor, arrival, fault, vehicle_count} !== '0) begin
      failures++;
      $display("FAIL midop_async_reset got s=%b a=%b f=%b c=%0d want 0", sensor, arrival, fault, vehicle_count);
    end
    reset_model();
    loop_raw = 1'b0;
    step(); step();
    @(negedge clk);
    rst_bar = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (arrival !== 1'b0 || sensor !== 1'b0) begin
        failures++;
        $display("FAIL midop_release got a=%b s=%b want 0", arrival, sensor);
      end
    end
  endtask

  task automatic test_random();
    int run;
    for (int blk = 0; blk < 300; blk++) begin
      loop_raw = ~loop_raw;
      run = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(1, 35);
      for (int i = 0; i < run; i++) begin
        count_clr = ($urandom_range(0, 40) == 0);
        step();
        checks++;
        if (sensor !== (m_occ | m_flt) || fault !== m_flt || arrival !== m_arr ||
            vehicle_count !== CNT_W'(m_cnt)) begin
          failures++;
          $display("FAIL random_model blk=%0d got s=%b f=%b a=%b c=%0d want s=%b f=%b a=%b c=%0d",
                   blk, sensor, fault, arrival, vehicle_count, m_occ | m_flt, m_flt, m_arr, m_cnt);
        end
      end
    end
    count_clr = 1'b0;
  endtask

  initial begin
    reset_model();
    test_reset();
    test_clean_arrival();
    test_bounce();
    test_hold_reentry();
    test_stuck();
    test_counter();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
